ime_sad_min_tracker: RTL and testbench

// - Consumer of the variable-block-size SAD set from the 16x16 IME PE array.
// - Accepts one candidate per cycle: 25 partition SADs plus the candidate MV.
// - Keeps the running minimum SAD and its MV for each partition across one search window.
// - Hands the per-partition winners to mode decision and pulses done.

---
 rtl/ime_sad_min_tracker_if.sv | 28 ++
 rtl/ime_sad_min_tracker.sv | 113 +++++++++++
 tb/tb_ime_sad_min_tracker.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ime_sad_min_tracker_if.sv
// Candidate/winner bus between the IME PE array, the SAD min tracker and mode decision.
interface ime_sad_min_tracker_if #(
   parameter int unsigned SADW = 16,
   parameter int unsigned MVW  = 7
);
   logic                 start;
   logic                 sad_valid;
   logic                 sad_last;
   logic [MVW-1:0]       mv_x;
   logic [MVW-1:0]       mv_y;
   logic [25*SADW-1:0]   sad_in;
   logic                 busy;
   logic                 done;
   logic [25*SADW-1:0]   best_sad;
   logic [25*MVW-1:0]    best_mvx;
   logic [25*MVW-1:0]    best_mvy;
   logic [15:0]          cand_cnt;

   modport master (
      output start, sad_valid, sad_last, mv_x, mv_y, sad_in,
      input  busy, done, best_sad, best_mvx, best_mvy, cand_cnt
   );

   modport slave (
      input  start, sad_valid, sad_last, mv_x, mv_y, sad_in,
      output busy, done, best_sad, best_mvx, best_mvy, cand_cnt
   );
endinterface

// File: rtl/ime_sad_min_tracker.sv
// Running per-partition SAD minimum tracker for one IME search window.
// Tracks 25 variable-block-size partitions independently; strict-less update keeps
// the earliest candidate on ties.
// Optional macro IME_MV_COST_EN adds LAMBDA*(|mv_x|+|mv_y|) to every partition SAD,
// saturated to SADW bits, before the compare.
module ime_sad_min_tracker #(
   parameter int unsigned SADW   = 16,
   parameter int unsigned MVW    = 7,
   parameter int unsigned LAMBDA = 4
) (
   input logic                    clk,
   input logic                    rst,
   ime_sad_min_tracker_if.slave   bus
);
   localparam int unsigned NP = 25;

   typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

   state_t          state;
   state_t          state_n;
   logic            accept_c;
   logic [SADW-1:0] cost [NP];

`ifdef IME_MV_COST_EN
   localparam int unsigned CW = SADW + MVW + 4;

   logic [MVW:0]  sx;
   logic [MVW:0]  sy;
   logic [MVW:0]  abs_x;
   logic [MVW:0]  abs_y;
   logic [CW-1:0] mv_cost;
   logic [CW-1:0] sum [NP];

   // Shared MV cost term: magnitudes computed one bit wider so -2^(MVW-1) fits.
   always_comb begin
      sx      = {bus.mv_x[MVW-1], bus.mv_x};
      sy      = {bus.mv_y[MVW-1], bus.mv_y};
      abs_x   = sx[MVW] ? (~sx + (MVW+1)'(1)) : sx;
      abs_y   = sy[MVW] ? (~sy + (MVW+1)'(1)) : sy;
      mv_cost = CW'(LAMBDA) * (CW'(abs_x) + CW'(abs_y));
   end

   // Per-partition cost with saturation to the SAD range.
   always_comb begin
      for (int p = 0; p < NP; p++) begin
         sum[p]  = CW'(bus.sad_in[p*SADW +: SADW]) + mv_cost;
         cost[p] = (sum[p][CW-1:SADW] != '0) ? {SADW{1'b1}} : sum[p][SADW-1:0];
      end
   end
`else
   logic unused_lambda;
   assign unused_lambda = ^(32'(LAMBDA));

   // Cost is the raw partition SAD.
   always_comb begin
      for (int p = 0; p < NP; p++) begin
         cost[p] = bus.sad_in[p*SADW +: SADW];
      end
   end
`endif

   // Candidate is taken only while searching and not overridden by a restart.
   assign accept_c = (state == SEARCH) && bus.sad_valid && !bus.start;

   // Next-state logic; start restarts the search from any state.
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (bus.start) state_n = SEARCH;
         SEARCH:  if (bus.sad_valid && bus.sad_last) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (bus.start) state_n = SEARCH;
   end

   // State register with registered busy/done decoded from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
      end else begin
         state    <= state_n;
         bus.busy <= (state_n == SEARCH);
         bus.done <= (state_n == DONE);
      end
   end

   // Winner registers and saturating candidate counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.best_sad <= '1;
         bus.best_mvx <= '0;
         bus.best_mvy <= '0;
         bus.cand_cnt <= '0;
      end else if (bus.start) begin
         bus.best_sad <= '1;
         bus.best_mvx <= '0;
         bus.best_mvy <= '0;
         bus.cand_cnt <= '0;
      end else if (accept_c) begin
         for (int p = 0; p < NP; p++) begin
            if (cost[p] < bus.best_sad[p*SADW +: SADW]) begin
               bus.best_sad[p*SADW +: SADW] <= cost[p];
               bus.best_mvx[p*MVW +: MVW]   <= bus.mv_x;
               bus.best_mvy[p*MVW +: MVW]   <= bus.mv_y;
            end
         end
         if (bus.cand_cnt != 16'hFFFF) bus.cand_cnt <= bus.cand_cnt + 16'd1;
      end
   end
endmodule

// File: tb/tb_ime_sad_min_tracker.sv
// Directed bench for ime_sad_min_tracker (default build; MV-cost cases under IME_MV_COST_EN).
module tb_ime_sad_min_tracker;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   ime_sad_min_tracker_if #(.SADW(16), .MVW(7)) bus ();

   ime_sad_min_tracker #(.SADW(16), .MVW(7), .LAMBDA(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [399:0] fill(input int val);
      logic [399:0] v;
      for (int p = 0; p < 25; p++) v[p*16 +: 16] = 16'(val);
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [399:0] v, input int mx, input int my, input logic last);
      bus.sad_valid = 1'b1;
      bus.sad_last  = last;
      bus.sad_in    = v;
      bus.mv_x      = 7'(mx);
      bus.mv_y      = 7'(my);
      step();
      bus.sad_valid = 1'b0;
      bus.sad_last  = 1'b0;
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      step();
      step();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", bus.done); end
      checks++; if (bus.cand_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bus.cand_cnt); end
      checks++; if (bus.best_sad !== {400{1'b1}}) begin errors++; $display("FAIL reset_best_sad got %0h exp all ones", bus.best_sad); end
      checks++; if (bus.best_mvx !== '0 || bus.best_mvy !== '0) begin errors++; $display("FAIL reset_mv got %0h/%0h exp 0", bus.best_mvx, bus.best_mvy); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic_min();
      logic [399:0] v;
      do_start();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL start_busy got %0b exp 1", bus.busy); end
      v = fill(1000); v[24*16 +: 16] = 16'd300; drive(v, 1, 1, 1'b0);
      v[24*16 +: 16] = 16'd120; drive(v, -2, 3, 1'b0);
      v[24*16 +: 16] = 16'd500; drive(v, 0, 0, 1'b1);
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL basic_done got %0b exp 1", bus.done); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %0b exp 0", bus.busy); end
      checks++; if (bus.best_sad[24*16 +: 16] !== 16'd120) begin errors++; $display("FAIL basic_sad24 got %0d exp 120", bus.best_sad[24*16 +: 16]); end
      checks++; if (bus.best_mvx[24*7 +: 7] !== 7'h7E) begin errors++; $display("FAIL basic_mvx24 got %0h exp 7e", bus.best_mvx[24*7 +: 7]); end
      checks++; if (bus.best_mvy[24*7 +: 7] !== 7'd3) begin errors++; $display("FAIL basic_mvy24 got %0d exp 3", bus.best_mvy[24*7 +: 7]); end
      checks++; if (bus.cand_cnt !== 16'd3) begin errors++; $display("FAIL basic_cnt got %0d exp 3", bus.cand_cnt); end
      checks++; if (bus.best_sad[0*16 +: 16] !== 16'd1000 || bus.best_mvx[0 +: 7] !== 7'd1) begin errors++; $display("FAIL basic_p0 got %0d/%0h exp 1000/1", bus.best_sad[0 +: 16], bus.best_mvx[0 +: 7]); end
      step();
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %0b exp 0", bus.done); end
      v = fill(5); drive(v, 9, 9, 1'b1);
      checks++; if (bus.best_sad[24*16 +: 16] !== 16'd120 || bus.cand_cnt !== 16'd3) begin errors++; $display("FAIL idle_ignore got %0d/%0d exp 120/3", bus.best_sad[24*16 +: 16], bus.cand_cnt); end
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL idle_flags got %0b/%0b exp 0/0", bus.done, bus.busy); end
   endtask

   task automatic test_tie();
      logic [399:0] v;
      do_start();
      v = fill(50); drive(v, 4, 0, 1'b0);
      drive(v, 0, 0, 1'b1);
      checks++; if (bus.best_mvx[0 +: 7] !== 7'd4) begin errors++; $display("FAIL tie_mvx0 got %0d exp 4", bus.best_mvx[0 +: 7]); end
      checks++; if (bus.best_sad[0 +: 16] !== 16'd50) begin errors++; $display("FAIL tie_sad0 got %0d exp 50", bus.best_sad[0 +: 16]); end
   endtask

   task automatic test_start_priority();
      logic [399:0] v;
      do_start();
      v = fill(100); drive(v, 2, 2, 1'b0);
      bus.start = 1'b1;
      v = fill(1); drive(v, 5, 5, 1'b0);
      bus.start = 1'b0;
      checks++; if (bus.best_sad[0 +: 16] !== 16'hFFFF) begin errors++; $display("FAIL prio_cleared got %0h exp ffff", bus.best_sad[0 +: 16]); end
      checks++; if (bus.cand_cnt !== 16'd0) begin errors++; $display("FAIL prio_cnt got %0d exp 0", bus.cand_cnt); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL prio_busy got %0b exp 1", bus.busy); end
      v = fill(7); drive(v, 1, 2, 1'b1);
      checks++; if (bus.done !== 1'b1 || bus.best_sad[0 +: 16] !== 16'd7 || bus.cand_cnt !== 16'd1) begin errors++; $display("FAIL prio_after got %0b/%0d/%0d exp 1/7/1", bus.done, bus.best_sad[0 +: 16], bus.cand_cnt); end
   endtask

   task automatic test_back_to_back_independent();
      logic [399:0] v;
      // start issued in the DONE cycle of the previous search
      do_start();
      checks++; if (bus.busy !== 1'b1 || bus.cand_cnt !== 16'd0) begin errors++; $display("FAIL b2b_start got %0b/%0d exp 1/0", bus.busy, bus.cand_cnt); end
      v = fill(500); v[0 +: 16] = 16'd10; v[16 +: 16] = 16'd90; drive(v, 1, 0, 1'b0);
      v[0 +: 16] = 16'd20; v[16 +: 16] = 16'd30; drive(v, 2, 0, 1'b1);
      checks++; if (bus.best_sad[0 +: 16] !== 16'd10 || bus.best_mvx[0 +: 7] !== 7'd1) begin errors++; $display("FAIL indep_p0 got %0d/%0d exp 10/1", bus.best_sad[0 +: 16], bus.best_mvx[0 +: 7]); end
      checks++; if (bus.best_sad[16 +: 16] !== 16'd30 || bus.best_mvx[7 +: 7] !== 7'd2) begin errors++; $display("FAIL indep_p1 got %0d/%0d exp 30/2", bus.best_sad[16 +: 16], bus.best_mvx[7 +: 7]); end
      step();
   endtask

   task automatic test_reset_mid();
      logic [399:0] v;
      int done_seen;
      done_seen = 0;
      do_start();
      v = fill(40); drive(v, 3, 3, 1'b0);
      drive(v, 3, 3, 1'b0);
      drive(v, 3, 3, 1'b0);
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.cand_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_async got %0b/%0d exp 0/0", bus.busy, bus.cand_cnt); end
      checks++; if (bus.best_sad !== {400{1'b1}} || bus.best_mvx !== '0 || bus.best_mvy !== '0) begin errors++; $display("FAIL rstmid_winners got %0h exp reset values", bus.best_sad[0 +: 16]); end
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (bus.done !== 1'b0) done_seen++;
         step();
      end
      checks++; if (done_seen != 0) begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", done_seen); end
   endtask

`ifdef IME_MV_COST_EN
   task automatic test_mv_cost();
      logic [399:0] v;
      do_start();
      v = fill(125); drive(v, 0, 0, 1'b0);
      v = fill(100); drive(v, 3, -2, 1'b1);
      checks++; if (bus.best_sad[24*16 +: 16] !== 16'd120) begin errors++; $display("FAIL cost_sad got %0d exp 120", bus.best_sad[24*16 +: 16]); end
      checks++; if (bus.best_mvx[24*7 +: 7] !== 7'd3 || bus.best_mvy[24*7 +: 7] !== 7'h7E) begin errors++; $display("FAIL cost_mv got %0h/%0h exp 3/7e", bus.best_mvx[24*7 +: 7], bus.best_mvy[24*7 +: 7]); end
      do_start();
      v = fill(16'hFFF0); drive(v, 10, 10, 1'b1);
      checks++; if (bus.best_sad[0 +: 16] !== 16'hFFFF || bus.best_mvx[0 +: 7] !== 7'd0) begin errors++; $display("FAIL cost_sat got %0h/%0d exp ffff/0", bus.best_sad[0 +: 16], bus.best_mvx[0 +: 7]); end
      step();
   endtask
`endif

   initial begin
      bus.start     = 1'b0;
      bus.sad_valid = 1'b0;
      bus.sad_last  = 1'b0;
      bus.mv_x      = '0;
      bus.mv_y      = '0;
      bus.sad_in    = '0;
      test_reset();
      test_basic_min();
      test_tie();
      test_start_priority();
      test_back_to_back_independent();
      test_reset_mid();
`ifdef IME_MV_COST_EN
      test_mv_cost();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
